rv_plic_claim_ctrl: RTL
=======================

// Module: rv_plic_claim_ctrl
// PURPOSE
//  Interrupt gateway and claim/complete sequencer sitting in front of the per-target
//  priority/threshold trees. Converts raw level/edge sources into pending bits
//  (ip_o feeds every target tree). It runs the claim -> service -> complete
//  handshake, so a source is delivered to exactly one target at a time.
//  It also arbitrates claims that several targets make in the same cycle.
// PARAMETERS
//  N_SOURCE  32  number of interrupt sources; ID 0 is reserved ("no interrupt")
//  N_TARGET  2   number of claiming targets (hart contexts)
//  SrcWidth  $clog2(N_SOURCE+1)  localparam, ID width
// PORTS
//  clk_i          in   1                   clock
//  rst_ni         in   1                   reset, asynchronous, active-low
//  src_i          in   N_SOURCE            raw sources, already synchronous to clk_i
//  le_i           in   N_SOURCE            1 = edge-triggered, 0 = level-triggered
//  claim_i        in   N_TARGET            one-cycle claim strobe per target
//  claim_id_i     in   N_TARGET x SrcWidth ID the target's tree reports at claim time
//  complete_i     in   N_TARGET            one-cycle completion strobe per target
//  complete_id_i  in   N_TARGET x SrcWidth ID being completed
//  ip_o           out  N_SOURCE            pending bits to target trees; bit 0 tied 0
//  claim_id_o     out  N_TARGET x SrcWidth granted ID, registered; 0 = nothing granted
//  claim_vld_o    out  N_TARGET            pulse, claim_id_o valid (1 cycle after claim_i)
//  cmpl_err_o     out  N_TARGET            pulse, completion rejected (wrong ID/owner)
// BEHAVIOUR
//  - Reset: all gateways IDLE, owner=0, defer=0, src_q=0; ip_o=0, claim_id_o=0,
//    claim_vld_o=0, cmpl_err_o=0.
//  - Gateway states per source k>=1: IDLE, PENDING, ACTIVE. ip_o[k] = (state==PENDING).
//  - Trigger: level: src_i[k]. Edge: src_i[k] & ~src_q[k] (src_q registered each cycle).
//  - IDLE: trigger -> PENDING. ip_o rises 1 cycle after the trigger.
//  - PENDING: claim granted -> ACTIVE, owner <= target. Otherwise hold. A level source
//    stays PENDING even if src_i drops. Pending is sticky until claimed.
//  - ACTIVE: the trigger is ignored for level sources. For edge sources an edge sets
//    defer=1 (one edge of depth; further edges are lost).
//    complete_i[t] with complete_id_i[t]==k and owner==t:
//      defer=1 -> PENDING and clear defer; otherwise -> IDLE.
//    A level source still high re-pends from IDLE on the next cycle.
//  - Claim arbitration: per cycle, for each ID, the lowest-index target with
//    claim_i & claim_id_i==ID wins. Losing targets get claim_id_o=0 with claim_vld_o=1.
//  - Claim rejection: claim of ID 0, ID >= N_SOURCE, or a non-PENDING source -> claim_id_o=0.
//  - Completion rejection: cmpl_err_o[t]=1 the next cycle and no state change when the ID
//    is 0, out of range, not ACTIVE, or owned by another target.
//  - Latency: claim_i (cycle n) -> claim_vld_o/claim_id_o and ip_o[k]=0 in cycle n+1.
//    complete_i (cycle n) -> state change visible in cycle n+1.
//  - Simultaneous events on one source:
//    - claim + trigger while PENDING: claim wins.
//    - complete + edge while ACTIVE: defer counts the edge, so the source re-pends.
//    - claim of k + complete of k cannot both act, because claim needs PENDING and
//      complete needs ACTIVE.
//  - Two targets completing the same ID: only the owner acts; the other gets cmpl_err_o.
//  - le_i changing while ACTIVE takes effect at the next trigger evaluation; no state flush.
//  - Reset mid-operation: all claims are dropped and every source returns to IDLE.
//    Level sources still high re-pend 1 cycle after reset release.
// STRUCTURE
//  - Package rv_plic_claim_pkg: gw_state_e {GW_IDLE, GW_PENDING, GW_ACTIVE};
//    function id_valid(id, N_SOURCE).
//  - Sub-module rv_plic_gateway: one per source, instantiated for k=1..N_SOURCE-1.
//    Inputs: trigger, le, claim_grant, complete_ok. Outputs: state/ip, owner.
//  - Top level holds the claim arbiter (fixed priority by target index), the
//    completion checker, and the claim_id_o/claim_vld_o/cmpl_err_o registers.
// TESTING
//  1. Level src 5 high at cycle 0 -> ip_o[5]=1 at cycle 1; claim t0 ID 5 ->
//     claim_id_o[0]=5 and ip_o[5]=0 next cycle; complete t0 ID 5 with src low -> IDLE,
//     no re-pend.
//  2. Edge src 3: pulse, claim by t1, second pulse while ACTIVE, complete t1 ID 3 ->
//     ip_o[3]=1 the cycle after completion (deferred edge); third pulse while ACTIVE is lost.
//  3. t0 and t1 both claim ID 7 in the same cycle -> claim_id_o[0]=7, claim_id_o[1]=0,
//     claim_vld_o=2'b11.
//  4. t1 completes ID 7 owned by t0 -> cmpl_err_o[1]=1, source 7 stays ACTIVE;
//     complete ID 0 -> cmpl_err_o pulses.
//  5. Claim ID 9 while IDLE -> claim_id_o=0; claim ID 0 -> claim_id_o=0; ip_o[0]
//     always 0 even with src_i[0]=1.
//  6. Assert rst_ni while sources 2 and 4 are ACTIVE and src_i[2] is held high ->
//     all outputs 0 immediately; ip_o[2]=1 one cycle after release, ip_o[4]=0.

Source files
------------

// File: rtl/rv_plic_claim_pkg.sv
// Shared types and helpers for the PLIC gateway / claim-complete sequencer.
package rv_plic_claim_pkg;

  typedef enum logic [1:0] {
    GW_IDLE    = 2'd0,
    GW_PENDING = 2'd1,
    GW_ACTIVE  = 2'd2
  } gw_state_e;

  // ID 0 means "no interrupt"; IDs at or above the source count do not exist.
  function automatic logic id_valid(input int unsigned id, input int unsigned n_source);
    return (id != 0) && (id < n_source);
  endfunction

endpackage

// File: rtl/rv_plic_gateway.sv
// Per-source gateway: turns a trigger into a sticky pending bit and tracks which
// target currently owns the interrupt until it is completed.
module rv_plic_gateway
  import rv_plic_claim_pkg::*;
#(
  parameter int TgtWidth = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                trigger,
  input  logic                le,
  input  logic                claim_grant,
  input  logic [TgtWidth-1:0] claim_tgt,
  input  logic                complete_ok,
  output logic                ip,
  output logic                active,
  output logic [TgtWidth-1:0] owner
);

  gw_state_e           state_q, state_d;
  logic                defer_q, defer_d;
  logic [TgtWidth-1:0] owner_q, owner_d;

  // State, deferred-edge flag and owner registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= GW_IDLE;
      defer_q <= 1'b0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      defer_q <= defer_d;
      owner_q <= owner_d;
    end
  end

  // Next-state logic; an edge arriving while ACTIVE (even in the completion
  // cycle) is remembered once so the source re-pends after completion.
  always_comb begin
    state_d = state_q;
    defer_d = defer_q;
    owner_d = owner_q;
    unique case (state_q)
      GW_IDLE: begin
        if (trigger) state_d = GW_PENDING;
      end
      GW_PENDING: begin
        if (claim_grant) begin
          state_d = GW_ACTIVE;
          owner_d = claim_tgt;
        end
      end
      GW_ACTIVE: begin
        if (le && trigger) defer_d = 1'b1;
        if (complete_ok) begin
          state_d = (defer_q || (le && trigger)) ? GW_PENDING : GW_IDLE;
          defer_d = 1'b0;
        end
      end
      default: state_d = GW_IDLE;
    endcase
  end

  assign ip     = (state_q == GW_PENDING);
  assign active = (state_q == GW_ACTIVE);
  assign owner  = owner_q;

endmodule

// File: rtl/rv_plic_claim_ctrl.sv
// Gateways for all sources plus the fixed-priority claim arbiter and the
// completion checker shared by all targets.
module rv_plic_claim_ctrl
  import rv_plic_claim_pkg::*;
#(
  parameter int N_SOURCE = 32,
  parameter int N_TARGET = 2,
  localparam int SrcWidth = $clog2(N_SOURCE + 1),
  localparam int TgtWidth = (N_TARGET > 1) ? $clog2(N_TARGET) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [N_SOURCE-1:0]          src_i,
  input  logic [N_SOURCE-1:0]          le_i,
  input  logic [N_TARGET-1:0]          claim_i,
  input  logic [N_TARGET*SrcWidth-1:0] claim_id_i,
  input  logic [N_TARGET-1:0]          complete_i,
  input  logic [N_TARGET*SrcWidth-1:0] complete_id_i,
  output logic [N_SOURCE-1:0]          ip_o,
  output logic [N_TARGET*SrcWidth-1:0] claim_id_o,
  output logic [N_TARGET-1:0]          claim_vld_o,
  output logic [N_TARGET-1:0]          cmpl_err_o
);

  logic [N_SOURCE-1:1]          src_q;
  logic [N_SOURCE-1:1]          ip_vec;
  logic [N_SOURCE-1:1]          act_vec;
  logic [N_SOURCE-1:1]          grant_vec;
  logic [N_SOURCE-1:1]          cmpl_vec;
  logic [TgtWidth-1:0]          owner     [N_SOURCE-1:1];
  logic [TgtWidth-1:0]          grant_tgt [N_SOURCE-1:1];
  logic [N_TARGET*SrcWidth-1:0] claim_id_d;
  logic [N_TARGET-1:0]          cmpl_err_d;

  // Source 0 is reserved and never produces a pending bit.
  logic unused_src0;
  assign unused_src0 = src_i[0] ^ le_i[0];

  for (genvar k = 1; k < N_SOURCE; k++) begin : g_gw
    logic trig;
    assign trig = le_i[k] ? (src_i[k] & ~src_q[k]) : src_i[k];

    rv_plic_gateway #(
      .TgtWidth (TgtWidth)
    ) u_gw (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .trigger     (trig),
      .le          (le_i[k]),
      .claim_grant (grant_vec[k]),
      .claim_tgt   (grant_tgt[k]),
      .complete_ok (cmpl_vec[k]),
      .ip          (ip_vec[k]),
      .active      (act_vec[k]),
      .owner       (owner[k])
    );
  end

  assign ip_o = {ip_vec, 1'b0};

  // Claim arbitration (lowest target index wins per ID) and completion checking.
  always_comb begin
    logic [SrcWidth-1:0] cid;
    logic [SrcWidth-1:0] did;
    logic                blocked;
    logic                ok;
    cid        = '0;
    did        = '0;
    blocked    = 1'b0;
    ok         = 1'b0;
    claim_id_d = '0;
    cmpl_err_d = '0;
    grant_vec  = '0;
    cmpl_vec   = '0;
    for (int k = 1; k < N_SOURCE; k++) grant_tgt[k] = '0;

    for (int t = 0; t < N_TARGET; t++) begin
      cid     = claim_id_i[t*SrcWidth +: SrcWidth];
      blocked = 1'b0;
      for (int u = 0; u < t; u++) begin
        if (claim_i[u] && (claim_id_i[u*SrcWidth +: SrcWidth] == cid)) blocked = 1'b1;
      end
      if (claim_i[t] && !blocked && id_valid(32'(cid), N_SOURCE)) begin
        for (int k = 1; k < N_SOURCE; k++) begin
          if ((cid == SrcWidth'(k)) && ip_vec[k]) begin
            grant_vec[k]                       = 1'b1;
            grant_tgt[k]                       = TgtWidth'(t);
            claim_id_d[t*SrcWidth +: SrcWidth] = cid;
          end
        end
      end

      did = complete_id_i[t*SrcWidth +: SrcWidth];
      ok  = 1'b0;
      if (complete_i[t] && id_valid(32'(did), N_SOURCE)) begin
        for (int k = 1; k < N_SOURCE; k++) begin
          if ((did == SrcWidth'(k)) && act_vec[k] && (owner[k] == TgtWidth'(t))) begin
            cmpl_vec[k] = 1'b1;
            ok          = 1'b1;
          end
        end
      end
      cmpl_err_d[t] = complete_i[t] && !ok;
    end
  end

  // Registered responses and the edge-detect history.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_q       <= '0;
      claim_id_o  <= '0;
      claim_vld_o <= '0;
      cmpl_err_o  <= '0;
    end else begin
      src_q       <= src_i[N_SOURCE-1:1];
      claim_id_o  <= claim_id_d;
      claim_vld_o <= claim_i;
      cmpl_err_o  <= cmpl_err_d;
    end
  end

endmodule
